// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage
package if_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ibuf_entry_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam int INST_BYTES = 4;
endpackage

// File: rtl/if_fetch_unit_fifo.sv
// if_fifo: flushable synchronous FIFO with occupancy count and a zeroed head when empty
module if_fifo #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  T                       din_i,
  input  logic                   pop_i,
  output T                       dout_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != (AW+1)'(DEPTH)) | do_pop);
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    wr_d = flush_i ? '0 : wr_q + AW'(do_push);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i && do_push && !flush_i) mem_q[wr_q] <= din_i;
  end
  assign dout_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: credit-limited multi-outstanding instruction fetch with flushable instruction queue
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int IBUF_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_adel_o
);
  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  logic [31:0] fetch_pc_q, fetch_pc_d, pcq_head;
  logic halted_q, halted_d;
  logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, ibuf_count, pcq_count;
  logic credit, aligned, accept, adel_push, keep, ibuf_push, ibuf_pop;
  ibuf_entry_t ibuf_din, ibuf_head;
  always_comb begin
    credit = ({1'b0, ibuf_count} + {1'b0, outstanding_q}) < (CW+1)'(IBUF_DEPTH);
    aligned = fetch_pc_q[1:0] == 2'b00;
    inst_req_o = rst_i & !redirect_i & !halted_q & credit & aligned;
    accept = inst_req_o & inst_addr_ok_i;
    adel_push = rst_i & !redirect_i & !halted_q & credit & !aligned;
    keep = inst_data_ok_i & !redirect_i & (discard_q == '0);
    ibuf_push = keep | adel_push;
    ibuf_din = adel_push ? ibuf_entry_t'{pc: fetch_pc_q, inst: 32'h0, adel: 1'b1}
                         : ibuf_entry_t'{pc: pcq_head, inst: inst_rdata_i, adel: 1'b0};
    id_valid_o = ibuf_count != '0;
    ibuf_pop = id_valid_o & id_ready_i & !redirect_i;
    // accept is never high during a redirect, so one expression serves both cases
    outstanding_d = outstanding_q + CW'(accept) - CW'(inst_data_ok_i);
    discard_d = redirect_i ? outstanding_d : discard_q - CW'(inst_data_ok_i & (discard_q != '0));
    fetch_pc_d = redirect_i ? redirect_pc_i : accept ? fetch_pc_q + 32'(INST_BYTES) : fetch_pc_q;
    halted_d = !redirect_i & (halted_q | adel_push);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC;
      halted_q <= 1'b0;
      outstanding_q <= '0;
      discard_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q <= halted_d;
      outstanding_q <= outstanding_d;
      discard_q <= discard_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) assert (!(inst_data_ok_i && ibuf_count == CW'(IBUF_DEPTH)) && (pcq_count + discard_q == outstanding_q));
  end
  if_fifo #(.T(ibuf_entry_t), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(redirect_i),
    .push_i(ibuf_push), .din_i(ibuf_din), .pop_i(ibuf_pop),
    .dout_o(ibuf_head), .count_o(ibuf_count)
  );
  if_fifo #(.T(logic [31:0]), .DEPTH(IBUF_DEPTH)) u_pcq (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(redirect_i),
    .push_i(accept), .din_i(fetch_pc_q), .pop_i(keep),
    .dout_o(pcq_head), .count_o(pcq_count)
  );
  assign inst_addr_o = fetch_pc_q;
  assign id_pc_o = ibuf_head.pc;
  assign id_inst_o = ibuf_head.inst;
  assign id_adel_o = ibuf_head.adel;
endmodule
